// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults, output mode encodings and the colour-bar palette.
package vga_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_BORDER = 2'd2,
        MODE_BLACK  = 2'd3
    } mode_e;

    typedef logic [11:0] rgb_t;

    localparam rgb_t BAR_RGB [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    // Index 8 and above marks the leftover pixels past the last full bar.
    function automatic rgb_t bar_colour(input logic [3:0] idx);
        return idx[3] ? 12'h000 : BAR_RGB[idx[2:0]];
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: D-stage register pipeline of width W; D == 0 degenerates to a wire.
module vga_delay_line #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    if (D == 0) begin : g_wire
        logic unused_clk;
        assign unused_clk = clk_i ^ rst_ni;
        assign q_o = d_i;
    end else begin : g_pipe
        logic [W-1:0] pipe_q [D];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < D; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= d_i;
                for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign q_o = pipe_q[D-1];
    end
endmodule

// File: rtl/vga_ctrl_param.sv
// vga_ctrl_param: parametrised VGA timing generator with latency-aligned sync, DE and test patterns.
module vga_ctrl_param
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int PIX_LATENCY = 1,
    parameter int CW          = 11
) (
    input  logic          clk_vga,
    input  logic          rst_vga,
    input  logic [1:0]    i_mode,
    input  logic [3:0]    i_r,
    input  logic [3:0]    i_g,
    input  logic [3:0]    i_b,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_frame_start,
    output logic          o_vga_hs,
    output logic          o_vga_vs,
    output logic [3:0]    o_vga_r,
    output logic [3:0]    o_vga_g,
    output logic [3:0]    o_vga_b,
    output logic          o_vga_de
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] X_LAST   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);
    localparam logic [3:0]    BAR_NONE  = 4'd8;
    localparam logic [3:0]    BAR_FIRST = (BAR_W == 0) ? BAR_NONE : 4'd0;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        mode_e         mode;
        logic [3:0]    bar;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } pix_t;

    logic          run_q;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [CW-1:0] bar_cnt_q, bar_cnt_d;
    logic [3:0]    bar_idx_q, bar_idx_d;
    mode_e         mode_q;
    logic          h_wrap;
    logic          border;
    pix_t          pix_raw, pix_dly;
    rgb_t          gfx, pat, rgb_q;
    logic          hs_q, vs_q, de_q;

    assign h_wrap = h_cnt_q == H_LAST;

    // Bar index tracks h_cnt incrementally so no divider is needed for H_ACTIVE/8.
    always_comb begin
        h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d   = !h_wrap ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        bar_cnt_d = (h_wrap || bar_cnt_q == BAR_LAST) ? '0 : bar_cnt_q + 1'b1;
        bar_idx_d = h_wrap ? BAR_FIRST
                  : (bar_idx_q != BAR_NONE && bar_cnt_q == BAR_LAST) ? bar_idx_q + 4'd1
                  : bar_idx_q;
    end

    assign o_x           = h_cnt_q;
    assign o_y           = v_cnt_q;
    assign o_frame_start = run_q && h_cnt_q == '0 && v_cnt_q == '0;

    // The first pixel's mode comes straight from i_mode so it matches the value latched into mode_q.
    always_comb begin
        pix_raw = '0;
        if (run_q) begin
            pix_raw.hs   = h_cnt_q >= HS_START && h_cnt_q < HS_END;
            pix_raw.vs   = v_cnt_q >= VS_START && v_cnt_q < VS_END;
            pix_raw.de   = h_cnt_q < H_VIS && v_cnt_q < V_VIS;
            pix_raw.mode = o_frame_start ? mode_e'(i_mode) : mode_q;
            pix_raw.bar  = bar_idx_q;
            pix_raw.x    = h_cnt_q;
            pix_raw.y    = v_cnt_q;
        end
    end

    vga_delay_line #(
        .W ($bits(pix_t)),
        .D (PIX_LATENCY)
    ) u_dly (
        .clk_i  (clk_vga),
        .rst_ni (rst_vga),
        .d_i    (pix_raw),
        .q_o    (pix_dly)
    );

    assign gfx    = {i_r, i_g, i_b};
    assign border = pix_dly.x == '0 || pix_dly.x == X_LAST || pix_dly.y == '0 || pix_dly.y == Y_LAST;
    assign pat    = (pix_dly.mode == MODE_BARS) ? bar_colour(pix_dly.bar)
                  : (pix_dly.mode == MODE_BORDER && border) ? 12'hFFF
                  : (pix_dly.mode == MODE_BLACK) ? 12'h000
                  : gfx;

    always_ff @(posedge clk_vga or negedge rst_vga) begin
        if (!rst_vga) begin
            run_q     <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= BAR_FIRST;
            mode_q    <= MODE_PASS;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            de_q      <= 1'b0;
            rgb_q     <= '0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                h_cnt_q   <= h_cnt_d;
                v_cnt_q   <= v_cnt_d;
                bar_cnt_q <= bar_cnt_d;
                bar_idx_q <= bar_idx_d;
            end
            if (o_frame_start) mode_q <= mode_e'(i_mode);
            hs_q  <= pix_dly.hs ? HS_POL : ~HS_POL;
            vs_q  <= pix_dly.vs ? VS_POL : ~VS_POL;
            de_q  <= pix_dly.de;
            rgb_q <= pix_dly.de ? pat : 12'h000;
        end
    end

    assign o_vga_hs = hs_q;
    assign o_vga_vs = vs_q;
    assign o_vga_de = de_q;
    assign {o_vga_r, o_vga_g, o_vga_b} = rgb_q;
endmodule

// File: tb/tb_vga_ctrl_param.sv
// tb_vga_ctrl_param: directed checks of timing, latency alignment, patterns, mode latching and reset
// on a shrunken 20x8 raster (A: latency 1, active-low syncs; B: latency 3, active-high hsync).
module tb_vga_ctrl_param;
    localparam int HA = 20, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam int CW = 8;
    localparam int LA = 1, LB = 3;

    logic          clk = 1'b0;
    logic          rst_vga = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [3:0]    in_r = 4'hA, in_g = 4'h5, in_b = 4'h3;
    logic [CW-1:0] xa, ya, xb, yb;
    logic          fsa, fsb, hsa, hsb, vsa, vsb, dea, deb;
    logic [3:0]    ra, ga, ba, rb, gb, bb;

    int e = 0;
    int n_tests = 0;
    int n_fail = 0;
    int fmode [16] = '{default: 0};
    bit stat_on = 1'b1;
    int st_de = 0, st_pix = 0, st_hs = 0, st_vs = 0;

    vga_ctrl_param #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LATENCY(LA), .CW(CW)
    ) u_a (
        .clk_vga(clk), .rst_vga(rst_vga), .i_mode(mode),
        .i_r(in_r), .i_g(in_g), .i_b(in_b),
        .o_x(xa), .o_y(ya), .o_frame_start(fsa),
        .o_vga_hs(hsa), .o_vga_vs(vsa),
        .o_vga_r(ra), .o_vga_g(ga), .o_vga_b(ba), .o_vga_de(dea)
    );

    vga_ctrl_param #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b0), .PIX_LATENCY(LB), .CW(CW)
    ) u_b (
        .clk_vga(clk), .rst_vga(rst_vga), .i_mode(mode),
        .i_r(in_r), .i_g(in_g), .i_b(in_b),
        .o_x(xb), .o_y(yb), .o_frame_start(fsb),
        .o_vga_hs(hsb), .o_vga_vs(vsb),
        .o_vga_r(rb), .o_vga_g(gb), .o_vga_b(bb), .o_vga_de(deb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int md, input int x, input int y, input logic [11:0] gfx);
        logic [11:0] bars [8];
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        if (x >= HA || y >= VA) return 12'h000;
        case (md)
            0: return gfx;
            1: return (x >= 8 * (HA / 8)) ? 12'h000 : bars[x / (HA / 8)];
            2: return (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? 12'hFFF : gfx;
            default: return 12'h000;
        endcase
    endfunction

    // Pins after edge e show the counter position that was current lat+1 cycles earlier.
    task automatic check_out(input string nm, input int lat, input bit hpol, input bit vpol,
                             input logic hs, input logic vs, input logic de, input logic [11:0] rgb);
        int p, h, v, f;
        bit ehs, evs, ede;
        logic [11:0] ergb;
        p = e - lat - 2;
        h = (p < 0) ? 0 : p % HT;
        v = (p < 0) ? 0 : (p / HT) % VT;
        f = (p < 0) ? 0 : p / FT;
        f = (f > 15) ? 15 : f;
        ehs = p >= 0 && h >= HA + HFP && h < HA + HFP + HSW;
        evs = p >= 0 && v >= VA + VFP && v < VA + VFP + VSW;
        ede = p >= 0 && h < HA && v < VA;
        ergb = ede ? model_rgb(fmode[f], h, v, {in_r, in_g, in_b}) : 12'h000;
        chk({nm, ".hs"}, hs, ehs ? hpol : !hpol);
        chk({nm, ".vs"}, vs, evs ? vpol : !vpol);
        chk({nm, ".de"}, de, ede);
        chk({nm, ".rgb"}, rgb, ergb);
        if (stat_on && nm == "A" && p >= 0 && p < FT) begin
            st_de  += int'(de);
            st_pix += int'(de && rgb == 12'hA53);
            st_hs  += int'(!hs);
            st_vs  += int'(!vs);
        end
    endtask

    task automatic check_all();
        int p;
        p = e - 1;
        chk("A.x", xa, (e == 0) ? 0 : p % HT);
        chk("A.y", ya, (e == 0) ? 0 : (p / HT) % VT);
        chk("A.fs", fsa, e >= 1 && p % FT == 0);
        chk("B.x", xb, (e == 0) ? 0 : p % HT);
        chk("B.fs", fsb, e >= 1 && p % FT == 0);
        check_out("A", LA, 1'b0, 1'b0, hsa, vsa, dea, {ra, ga, ba});
        check_out("B", LB, 1'b1, 1'b0, hsb, vsb, deb, {rb, gb, bb});
    endtask

    // The mode applied to a frame is whatever i_mode holds at the edge leaving its (0,0) cycle.
    task automatic tick();
        if (e >= 1 && (e - 1) % FT == 0 && (e - 1) / FT < 16) fmode[(e - 1) / FT] = int'(mode);
        @(posedge clk);
        e++;
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_e(input int t);
        while (e < t) tick();
    endtask

    task automatic at_a(input int f, input int x, input int y);
        wait_e(f * FT + y * HT + x + LA + 2);
    endtask

    initial begin
        #2 rst_vga = 1'b0;
        #10;
        chk("rst.x", xa, 0);
        chk("rst.y", ya, 0);
        chk("rst.fs", fsa, 0);
        chk("rst.de", dea, 0);
        chk("rst.rgb", {ra, ga, ba}, 12'h000);
        chk("rst.hsA", hsa, 1);
        chk("rst.hsB", hsb, 0);
        chk("rst.vsA", vsa, 1);
        @(negedge clk);
        rst_vga = 1'b1;
        tick();
        chk("first.fs", fsa, 1);
        chk("first.x", xa, 0);
        wait_e(2);
        chk("A.de_early", dea, 0);
        tick();
        chk("A.de_first", dea, 1);
        wait_e(4);
        chk("B.de_early", deb, 0);
        tick();
        chk("B.de_first", deb, 1);
        wait_e(24);
        chk("A.hs_pre", hsa, 1);
        tick();
        chk("A.hs_edge", hsa, 0);
        wait_e(26);
        chk("B.hs_pre", hsb, 0);
        tick();
        chk("B.hs_edge", hsb, 1);
        wait_e(4 * HT);
        mode = 2'd1;
        wait_e(FT + LA + 1);
        stat_on = 1'b0;
        chk("frame.de_cnt", st_de, 160);
        chk("frame.pix_cnt", st_pix, 160);
        chk("frame.hs_low", st_hs, 39);
        chk("frame.vs_low", st_vs, 56);
        at_a(1, 1, 3);  chk("bar.x1", {ra, ga, ba}, 12'hFFF);
        at_a(1, 2, 3);  chk("bar.x2", {ra, ga, ba}, 12'hFF0);
        at_a(1, 3, 3);  chk("bar.x3", {ra, ga, ba}, 12'hFF0);
        at_a(1, 4, 3);  chk("bar.x4", {ra, ga, ba}, 12'h0FF);
        at_a(1, 12, 3); chk("bar.x12", {ra, ga, ba}, 12'h00F);
        at_a(1, 14, 3); chk("bar.x14", {ra, ga, ba}, 12'h000);
        at_a(1, 16, 3); chk("bar.x16", {ra, ga, ba}, 12'h000);
        at_a(1, 19, 3); chk("bar.x19", {ra, ga, ba}, 12'h000);
        mode = 2'd2;
        at_a(2, 5, 0);  chk("bord.top", {ra, ga, ba}, 12'hFFF);
        at_a(2, 0, 1);  chk("bord.left", {ra, ga, ba}, 12'hFFF);
        at_a(2, 1, 1);  chk("bord.inner", {ra, ga, ba}, 12'hA53);
        at_a(2, 18, 1); chk("bord.inner18", {ra, ga, ba}, 12'hA53);
        at_a(2, 19, 1); chk("bord.right", {ra, ga, ba}, 12'hFFF);
        mode = 2'd3;
        at_a(2, 6, 6);  chk("late.inner", {ra, ga, ba}, 12'hA53);
        at_a(2, 5, 7);  chk("late.bottom", {ra, ga, ba}, 12'hFFF);
        at_a(3, 0, 0);  chk("black.first", {ra, ga, ba}, 12'h000);
        chk("black.de", dea, 1);
        at_a(3, 1, 1);  chk("black.inner", {ra, ga, ba}, 12'h000);
        wait_e(3 * FT + 3 * HT + 11);
        chk("mid.x", xa, 10);
        chk("mid.y", ya, 3);
        mode = 2'd0;
        #2 rst_vga = 1'b0;
        #1;
        chk("rst2.x", xa, 0);
        chk("rst2.y", ya, 0);
        chk("rst2.fs", fsa, 0);
        chk("rst2.deA", dea, 0);
        chk("rst2.deB", deb, 0);
        chk("rst2.rgb", {ra, ga, ba}, 12'h000);
        chk("rst2.hsA", hsa, 1);
        chk("rst2.hsB", hsb, 0);
        e = 0;
        for (int i = 0; i < 16; i++) fmode[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst2.hold_x", xa, 0);
        rst_vga = 1'b1;
        tick();
        chk("rel.fs", fsa, 1);
        chk("rel.y", ya, 0);
        wait_e(2 * HT + 8);
        chk("rel.line2_y", ya, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_ctrl_param.md
VGA_CTRL_PARAM -- requirements
Module: vga_ctrl_param

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameters HS_POL / VS_POL, default 0 / 0, active sync level (0 = active-low).
REQ-006 Parameter PIX_LATENCY, default 1, range 0..4, cycles from o_x/o_y to valid i_r/i_g/i_b.
REQ-007 Parameter CW, default 11, width of o_x/o_y.
REQ-008 clk_vga  in  1  pixel clock; all logic on rising edge.
REQ-009 rst_vga  in  1  reset; asynchronous assertion, active-low.
REQ-010 i_mode  in  2  output source: 0 graphics pass-through, 1 colour bars, 2 border test, 3 forced black.
REQ-011 i_r / i_g / i_b  in  4 each  pixel colour from graphics for the coordinate issued PIX_LATENCY cycles earlier.
REQ-012 o_x / o_y  out  CW each  raw horizontal/vertical counter values (visible when o_x<H_ACTIVE and o_y<V_ACTIVE).
REQ-013 o_frame_start  out  1  one-cycle pulse when counters are (0,0).
REQ-014 o_vga_hs / o_vga_vs  out  1 each  sync outputs, latency-aligned to RGB.
REQ-015 o_vga_r / o_vga_g / o_vga_b  out  4 each  registered pixel colour.
REQ-016 o_vga_de  out  1  registered display-enable aligned with RGB.

Function
REQ-017 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of four H params) and wrap to 0.
REQ-018 v_cnt SHALL increment when h_cnt wraps, counting 0..V_TOTAL-1, wrapping to 0 when both wrap together.
REQ-019 o_x = h_cnt, o_y = v_cnt, combinationally from the counter registers.
REQ-020 Raw hs active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vs likewise with V params; raw de when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-021 Raw hs/vs/de and pattern-coordinates SHALL pass through a PIX_LATENCY-deep shift pipeline, then one output register; pin latency from counter = PIX_LATENCY+1 cycles.
REQ-022 Sync pins SHALL drive HS_POL/VS_POL when active, the inverse otherwise.
REQ-023 Mode register SHALL load i_mode only on the cycle o_frame_start is high; mid-frame i_mode changes SHALL have no effect until the next frame.
REQ-024 Mode 1: eight vertical bars of width H_ACTIVE/8 (integer), left to right white F/F/F, yellow F/F/0, cyan 0/F/F, green 0/F/0, magenta F/0/F, red F/0/0, blue 0/0/F, black 0/0/0; pixels beyond 8*(H_ACTIVE/8) black.
REQ-025 Mode 2: white (F/F/F) when x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1; else graphics input.
REQ-026 Mode 3: RGB 0/0/0 on all pixels.
REQ-027 When delayed de is low, RGB pins SHALL be 0 regardless of mode or inputs.
REQ-028 Bar and border decisions SHALL use delayed coordinates so all modes share identical latency.

Reset
REQ-029 While rst_vga low: h_cnt=v_cnt=0, pipelines cleared (de=0, syncs inactive), RGB=0, o_vga_de=0, mode register=0, o_frame_start=0.
REQ-030 First rising edge after release SHALL present (0,0) with o_frame_start=1; reset mid-frame restarts timing from (0,0) with no partial sync pulse emitted.

Structure
REQ-031 Shared package vga_pkg SHALL hold default timing constants (640x480@60), mode encodings, and colour-bar RGB table.
REQ-032 One sub-module, vga_delay_line (parametrised width/depth, depth 0 = wire), SHALL implement the alignment pipeline.

Verification
REQ-033 Defaults, mode 0, i_r/g/b=A/5/3: hs low for 96 cycles per 800-cycle line, vs low for 2 lines per 525, RGB A/5/3 exactly 640x480 pixels per frame.
REQ-034 PIX_LATENCY=3: first o_vga_de high exactly 4 cycles after o_x=0,o_y=0 at frame start; hs edge offset identical.
REQ-035 Mode 1 at defaults: bar boundaries at pixels 80,160,...,560; pixel 85 yields F/F/0, pixel 639 yields 0/0/0.
REQ-036 i_mode 0->3 at line 100: output stays pass-through until next o_frame_start, then 0/0/0 from first pixel.
REQ-037 Mode 2: pixels (0,y), (639,y), (x,0), (x,479) white; (1,1) equals graphics input.
REQ-038 rst_vga pulsed low at (300,200): outputs zero asynchronously; after release o_frame_start within 1 cycle, no runt hs.
